// File: rtl/prog_loader.sv
// prog_loader: receives a program image as a little-endian byte stream and
// packs it into instruction words. It holds the core in reset until the whole
// image has arrived, then serves instruction fetches combinationally.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   s_valid      byte-stream valid
//   s_ready      byte-stream ready (high only while loading)
//   s_data[7:0]  program byte, little-endian within each instruction
//   s_last       final byte of the image
//   fetch_addr   core byte address; the low two bits are ignored
//   fetch_inst   instruction at fetch_addr, or NOP_INST if not loaded
//   core_rst     reset to the processor core, released only in RUN
//   load_done    high in RUN
//   load_err     high in ERROR
//   word_count   words written since reset, saturating at PROG_SIZE
//
// state | meaning
// LOAD  | accepting bytes, assembling and writing words
// HOLD  | image complete, core_rst held for RST_HOLD cycles
// RUN   | core released, fetches served
// ERROR | malformed or oversized image; waits for rst
module prog_loader #(
  parameter int                PROG_SIZE = 64,
  parameter int                INST_W    = 32,
  parameter int                RST_HOLD  = 4,
  parameter logic [INST_W-1:0] NOP_INST  = 32'h00000013,
  localparam int               ADDR_W    = $clog2(PROG_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  input  logic [31:0]       fetch_addr,
  output logic [INST_W-1:0] fetch_inst,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  localparam int BYTES = INST_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_LANE = BC_W'(BYTES - 1);
  localparam logic [ADDR_W:0] SIZE_CNT  = (ADDR_W + 1)'(PROG_SIZE);
  localparam logic [7:0]      HOLD_INIT = 8'(RST_HOLD);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  logic [1:0]        state;
  logic [BC_W-1:0]   byte_cnt;
  logic [7:0]        hold_cnt;
  logic [INST_W-1:0] asm_word;
  logic [INST_W-1:0] asm_next;
  logic [ADDR_W:0]   wc;
  logic [INST_W-1:0] mem [PROG_SIZE];

  logic accept;
  logic lane_last;
  logic mem_full;
  logic word_done;

  assign accept    = s_valid && (state == ST_LOAD);
  assign lane_last = (byte_cnt == LAST_LANE);
  assign mem_full  = (wc == SIZE_CNT);
  assign word_done = accept && lane_last;

  // Assembly register with the incoming byte merged in, so the completing
  // byte lands in memory on the same edge it is accepted.
  always_comb begin
    asm_next = asm_word;
    for (int i = 0; i < BYTES; i++) begin
      if (int'(byte_cnt) == i) asm_next[8*i +: 8] = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_LOAD;
      byte_cnt <= '0;
      wc       <= '0;
      hold_cnt <= HOLD_INIT;
      asm_word <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            asm_word <= asm_next;
            byte_cnt <= lane_last ? '0 : byte_cnt + 1'b1;
            if (lane_last) begin
              // A full word with no room left is an oversized image.
              if (mem_full) begin
                state <= ST_ERROR;
              end else begin
                wc <= wc + 1'b1;
                if (s_last) begin
                  state    <= ST_HOLD;
                  hold_cnt <= HOLD_INIT;
                end
              end
            end else if (s_last) begin
              state <= ST_ERROR;
            end
          end
        end
        ST_HOLD: begin
          if (hold_cnt <= 8'd1) state <= ST_RUN;
          else hold_cnt <= hold_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Memory is never cleared; word_count gates what fetches can see.
  always_ff @(posedge clk) begin
    if (!rst && word_done && !mem_full) mem[wc[ADDR_W-1:0]] <= asm_next;
  end

  logic [ADDR_W-1:0] fetch_idx;
  logic              upper_zero;
  logic              unused_addr_lo;

  assign fetch_idx      = fetch_addr[ADDR_W+1:2];
  assign upper_zero     = (fetch_addr[31:ADDR_W+2] == '0);
  assign unused_addr_lo = ^fetch_addr[1:0];
  assign fetch_inst     = (upper_zero && ({1'b0, fetch_idx} < wc)) ? mem[fetch_idx] : NOP_INST;

  assign s_ready    = (state == ST_LOAD);
  assign core_rst   = (state != ST_RUN);
  assign load_done  = (state == ST_RUN);
  assign load_err   = (state == ST_ERROR);
  assign word_count = wc;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: random byte streams against a queue-based image
// model, plus literal checks of the worked examples and a PROG_SIZE=2 instance.
module tb_prog_loader;
  localparam int          HOLD = 4;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, s_valid = 1'b0, s_last = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic [31:0] fetch_addr = 32'h0;
  logic        s_ready, core_rst, load_done, load_err;
  logic [31:0] fetch_inst;
  logic [6:0]  word_count;

  prog_loader #(.PROG_SIZE(64), .INST_W(32), .RST_HOLD(HOLD), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .fetch_addr(fetch_addr), .fetch_inst(fetch_inst),
    .core_rst(core_rst), .load_done(load_done), .load_err(load_err),
    .word_count(word_count));

  logic        sm_rst = 1'b1, sm_valid = 1'b0, sm_last = 1'b0;
  logic [7:0]  sm_data = 8'h00;
  logic [31:0] sm_addr = 32'h0;
  logic        sm_ready, sm_core_rst, sm_done, sm_err;
  logic [31:0] sm_inst;
  logic [1:0]  sm_wc;

  prog_loader #(.PROG_SIZE(2), .INST_W(32), .RST_HOLD(1), .NOP_INST(NOP)) dut_small (
    .clk(clk), .rst(sm_rst), .s_valid(sm_valid), .s_ready(sm_ready), .s_data(sm_data),
    .s_last(sm_last), .fetch_addr(sm_addr), .fetch_inst(sm_inst),
    .core_rst(sm_core_rst), .load_done(sm_done), .load_err(sm_err),
    .word_count(sm_wc));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_img [$];
  logic [31:0] m_mem [64];
  int          m_wc = 0;
  bit          m_err = 0, m_fin = 0, chk_en = 0;
  int          m_cyc = 0, m_fin_cyc = 0;

  function automatic bit m_ready();
    return !m_err && !m_fin;
  endfunction

  function automatic bit m_run();
    return m_fin && (m_cyc - m_fin_cyc >= HOLD);
  endfunction

  function automatic logic [31:0] m_fetch(input logic [31:0] a);
    if (a[31:8] != 24'd0) return NOP;
    if (int'(a[7:2]) < m_wc) return m_mem[a[7:2]];
    return NOP;
  endfunction

  always @(posedge clk) begin
    int n;
    m_cyc++;
    if (rst) begin
      m_img.delete();
      m_wc   = 0;
      m_err  = 0;
      m_fin  = 0;
      chk_en = 1;
    end else if (s_valid && m_ready()) begin
      m_img.push_back(s_data);
      n = m_img.size();
      if (n % 4 == 0) begin
        if (m_wc == 64) m_err = 1;
        else begin
          m_mem[m_wc] = {m_img[n-1], m_img[n-2], m_img[n-3], m_img[n-4]};
          m_wc++;
        end
      end
      if (s_last && !m_err) begin
        if (n % 4 == 0) begin
          m_fin     = 1;
          m_fin_cyc = m_cyc;
        end else m_err = 1;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("s_ready",    32'(s_ready),    32'(m_ready()));
      chk("core_rst",   32'(core_rst),   32'(!m_run()));
      chk("load_done",  32'(load_done),  32'(m_run()));
      chk("load_err",   32'(load_err),   32'(m_err));
      chk("word_count", 32'(word_count), 32'(m_wc));
      chk("fetch_inst", fetch_inst,      m_fetch(fetch_addr));
    end
  end

  // ---------------- stimulus ----------------
  bit          rand_fetch = 1;
  logic [31:0] fixed_addr = 32'h0;

  always @(negedge clk) begin
    if (rand_fetch) begin
      if ($urandom_range(3, 0) != 0) fetch_addr = {24'd0, 6'($urandom_range(15, 0)), 2'($urandom)};
      else fetch_addr = $urandom;
    end else fetch_addr = fixed_addr;
  end

  logic [7:0] img36 [8] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};

  task automatic drive_byte(input logic [7:0] d, input bit last, input int max_gap);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) begin
      @(negedge clk);
      s_valid = 0; s_data = 8'($urandom); s_last = 1'($urandom);
    end
    @(negedge clk);
    s_valid = 1; s_data = d; s_last = last;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); s_valid = 0; s_last = 0; end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; s_valid = 0;
    @(negedge clk); rst = 0;
  endtask

  task automatic reset_with_byte();
    @(negedge clk); rst = 1; s_valid = 1; s_data = 8'($urandom); s_last = 1'($urandom);
    @(negedge clk); rst = 0; s_valid = 0;
  endtask

  task automatic send36(input int max_gap);
    for (int i = 0; i < 8; i++) drive_byte(img36[i], i == 7, max_gap);
  endtask

  // Called at the negedge where the final byte is driven.
  task automatic wait_done(input string nm);
    int cnt;
    cnt = 0;
    while (!load_done && cnt < 20) begin
      @(negedge clk); s_valid = 0; cnt++;
    end
    chk(nm, 32'(cnt), 32'(HOLD + 1));
  endtask

  task automatic addr_check(input string nm, input logic [31:0] a, input logic [31:0] exp);
    rand_fetch = 0; fixed_addr = a;
    @(negedge clk); s_valid = 0;
    #1 chk(nm, fetch_inst, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 0; sm_rst = 0;
    #1;
    chk("rst_ready",    32'(s_ready),    32'd1);
    chk("rst_core_rst", 32'(core_rst),   32'd1);
    chk("rst_done",     32'(load_done),  32'd0);
    chk("rst_err",      32'(load_err),   32'd0);
    chk("rst_wc",       32'(word_count), 32'd0);
    addr_check("rst_fetch0", 32'h0, NOP);

    // Worked example image, no gaps.
    rand_fetch = 1;
    do_reset();
    send36(0);
    wait_done("t36_hold_len");
    idle(1);
    chk("t36_wc",       32'(word_count), 32'd2);
    chk("t36_core_rst", 32'(core_rst),   32'd0);
    chk("model_mem0",   m_mem[0],        32'h00500513);
    addr_check("t36_f0",   32'h0,         32'h00500513);
    addr_check("t37_f4",   32'h4,         32'h00A00593);
    addr_check("t37_f6",   32'h6,         32'h00A00593);
    addr_check("t37_f8",   32'h8,         NOP);
    addr_check("t37_fhi",  32'h1000_0000, NOP);
    rand_fetch = 1;
    repeat (4) begin
      @(negedge clk); s_valid = 1; s_data = 8'($urandom); s_last = 1'($urandom);
    end
    idle(1);
    chk("run_ignore_wc", 32'(word_count), 32'd2);

    // Premature s_last on lane 1 of the second word.
    do_reset();
    for (int i = 0; i < 6; i++) drive_byte(img36[i], i == 5, 0);
    idle(2);
    chk("t38_err",      32'(load_err),   32'd1);
    chk("t38_core_rst", 32'(core_rst),   32'd1);
    chk("t38_ready",    32'(s_ready),    32'd0);
    chk("t38_wc",       32'(word_count), 32'd1);

    // Same image with random valid gaps.
    rand_fetch = 1;
    do_reset();
    send36(3);
    wait_done("t40_hold_len");
    idle(1);
    addr_check("t40_f0", 32'h0, 32'h00500513);
    addr_check("t40_f4", 32'h4, 32'h00A00593);

    // Reset mid-load, then reload; old word 1 must stay hidden until rewritten.
    rand_fetch = 1;
    do_reset();
    for (int i = 0; i < 5; i++) drive_byte(img36[i], 1'b0, 1);
    do_reset();
    rand_fetch = 0; fixed_addr = 32'h4;
    for (int i = 0; i < 8; i++) begin
      drive_byte(img36[i], i == 7, 0);
      if (i == 5) #1 chk("t41_f4_early", fetch_inst, NOP);
    end
    wait_done("t41_hold_len");
    addr_check("t41_f4", 32'h4, 32'h00A00593);

    // Random images, some malformed, some abandoned by reset.
    for (int it = 0; it < 30; it++) begin
      int nw, nb;
      bit do_last;
      rand_fetch = 1;
      if ($urandom_range(3, 0) == 0) reset_with_byte();
      else do_reset();
      nw = $urandom_range(10, 1);
      nb = nw * 4;
      if ($urandom_range(3, 0) == 0) nb = nb - int'($urandom_range(3, 1));
      do_last = (it % 5 != 4);
      for (int b = 0; b < nb; b++) drive_byte(8'($urandom), do_last && (b == nb - 1), 2);
      repeat (HOLD + 4) begin
        @(negedge clk);
        s_valid = 1'($urandom); s_data = 8'($urandom); s_last = 1'($urandom);
      end
      idle(1);
    end

    // Oversized image: 65 words into 64.
    rand_fetch = 1;
    do_reset();
    for (int b = 0; b < 260; b++) drive_byte(8'(b * 7), b == 259, 0);
    idle(2);
    chk("ovf_err",   32'(load_err),   32'd1);
    chk("ovf_wc",    32'(word_count), 32'd64);
    chk("ovf_ready", 32'(s_ready),    32'd0);
    addr_check("ovf_f63",  32'hFC,  32'hF9F2EBE4);
    addr_check("ovf_f64",  32'h100, NOP);

    // PROG_SIZE=2 instance: third word must not overwrite memory.
    @(negedge clk); sm_rst = 1;
    @(negedge clk); sm_rst = 0;
    for (int b = 0; b < 12; b++) begin
      @(negedge clk);
      sm_valid = 1; sm_data = 8'(b + 1); sm_last = (b == 11);
      if (b == 11) begin
        #1;
        chk("sm_err_before", 32'(sm_err), 32'd0);
        chk("sm_wc_before",  32'(sm_wc),  32'd2);
      end
    end
    @(negedge clk); sm_valid = 0; sm_last = 0;
    #1;
    chk("sm_err",      32'(sm_err),      32'd1);
    chk("sm_wc",       32'(sm_wc),       32'd2);
    chk("sm_ready",    32'(sm_ready),    32'd0);
    chk("sm_core_rst", 32'(sm_core_rst), 32'd1);
    sm_addr = 32'h0; #1 chk("sm_f0", sm_inst, 32'h04030201);
    sm_addr = 32'h4; #1 chk("sm_f4", sm_inst, 32'h08070605);
    sm_addr = 32'h8; #1 chk("sm_f8", sm_inst, NOP);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
